pipo_load_arbiter: RTL

PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

---
 rtl/pipo_ctrl_pkg.sv | 16 +
 rtl/pipo_rr_pick.sv | 33 +++
 rtl/pipo_load_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipo_ctrl_pkg.sv
// Shared types and default sizing for the parallel-load arbiter.
// Imported by the round-robin picker and the arbiter top.
package pipo_ctrl_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_WIDTH       = 4;
    localparam int DEF_HOLD_CYCLES = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/pipo_rr_pick.sv
// Combinational round-robin picker: first set request at or above
// the pointer, wrapping from NUM_REQ-1 back to 0.
module pipo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      pointer_i,
    output logic               valid_o,
    output logic [NUM_REQ-1:0] win_oh_o,
    output logic [IW-1:0]      win_idx_o
);

    logic w_found;
    int   w_k;

    always_comb begin
        w_found   = 1'b0;
        w_k       = 0;
        win_oh_o  = '0;
        win_idx_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_k = (int'(pointer_i) + i) % NUM_REQ;
            if (!w_found && req_i[w_k]) begin
                w_found        = 1'b1;
                win_oh_o[w_k]  = 1'b1;
                win_idx_o      = IW'(w_k);
            end
        end
        valid_o = w_found;
    end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Arbitrates requesters for one shared parallel-load register:
// IDLE picks a winner, LOAD strobes it in, HOLD idles HOLD_CYCLES.
module pipo_load_arbiter
    import pipo_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*WIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       load_o,
    output logic [WIDTH-1:0]           load_data_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o
);

    localparam int IW = $clog2(NUM_REQ);

    state_t             r_state;
    state_t             w_next;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_owner;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_data;

    logic               w_valid;
    logic               w_capture;
    logic [NUM_REQ-1:0] w_win_oh;
    logic [IW-1:0]      w_win_idx;
    logic [WIDTH-1:0]   w_sel;
    logic [IW-1:0]      w_ptr_nxt;

    pipo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i     (req_i),
        .pointer_i (r_ptr),
        .valid_o   (w_valid),
        .win_oh_o  (w_win_oh),
        .win_idx_o (w_win_idx)
    );

    // AND-OR mux keyed by the one-hot winner.
    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win_oh[k]) begin
                w_sel |= data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_valid) begin
                    w_next    = ST_LOAD;
                    w_capture = 1'b1;
                end
            end
            ST_LOAD: begin
                w_next = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_ptr_nxt = (r_owner == IW'(NUM_REQ - 1)) ? '0
                     : r_owner + IW'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            if (w_capture) begin
                r_data  <= w_sel;
                r_owner <= w_win_idx;
            end
            if (r_state == ST_LOAD) begin
                r_ptr <= w_ptr_nxt;
                r_cnt <= CNT_W'(HOLD_CYCLES);
            end else if (r_state == ST_HOLD && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign load_o      = (r_state == ST_LOAD);
    assign busy_o      = (r_state != ST_IDLE);
    assign gnt_o       = load_o ? (NUM_REQ'(1) << r_owner) : '0;
    assign load_data_o = r_data;
    assign owner_o     = r_owner;

endmodule
